// File: rtl/vram_arbiter_pkg.sv
// Shared widths, slot encoding and write-queue payload for the VRAM arbiter.
// No ports; imported by the interface, the write FIFO and the arbiter top.
package vram_arbiter_pkg;

    localparam int unsigned VRAM_ADDR_W = 12;
    localparam int unsigned VRAM_DATA_W = 8;
    localparam int unsigned STAT_W      = 8;

    // Per-cycle VRAM slot owner
    localparam logic [1:0] SLOT_IDLE  = 2'd0;
    localparam logic [1:0] SLOT_GPU   = 2'd1;
    localparam logic [1:0] SLOT_CPU   = 2'd2;
    localparam logic [1:0] SLOT_FORCE = 2'd3;

    // One queued CPU store
    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] address;
        logic [VRAM_DATA_W-1:0] data;
    } wr_entry_t;

    localparam int unsigned WR_ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle of the VRAM arbiter: CPU store port, GPU read port, VRAM macro port.
//   slave  : arbiter side (consumes CPU/GPU requests and VRAM read data)
//   master : environment side (address decode, GPU fetch, VRAM macro)
interface vram_arbiter_if;
    import vram_arbiter_pkg::*;

    // CPU store port
    logic                   cpu_wr_strobe;
    logic [VRAM_ADDR_W-1:0] cpu_address;
    logic [VRAM_DATA_W-1:0] cpu_data;
    logic                   wr_fifo_full;
    logic                   wr_fifo_empty;
    logic                   wr_overflow;
    logic                   clr_overflow;
    // GPU read port
    logic                   in_vblank;
    logic                   gpu_rd_req;
    logic [VRAM_ADDR_W-1:0] gpu_rd_address;
    logic                   gpu_rd_grant;
    logic                   gpu_rd_valid;
    logic [VRAM_DATA_W-1:0] gpu_rd_data;
    // VRAM macro port
    logic [VRAM_ADDR_W-1:0] vram_address;
    logic                   vram_write_enable;
    logic [VRAM_DATA_W-1:0] vram_data_out;
    logic [VRAM_DATA_W-1:0] vram_data_in;

    modport slave (
        input  cpu_wr_strobe, cpu_address, cpu_data, clr_overflow,
        input  in_vblank, gpu_rd_req, gpu_rd_address, vram_data_in,
        output wr_fifo_full, wr_fifo_empty, wr_overflow,
        output gpu_rd_grant, gpu_rd_valid, gpu_rd_data,
        output vram_address, vram_write_enable, vram_data_out
    );

    modport master (
        output cpu_wr_strobe, cpu_address, cpu_data, clr_overflow,
        output in_vblank, gpu_rd_req, gpu_rd_address, vram_data_in,
        input  wr_fifo_full, wr_fifo_empty, wr_overflow,
        input  gpu_rd_grant, gpu_rd_valid, gpu_rd_data,
        input  vram_address, vram_write_enable, vram_data_out
    );

endinterface

// File: rtl/vram_arbiter_wr_fifo.sv
// Synchronous circular FIFO for queued CPU stores (first-word fall-through head).
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata, full, empty.
// Pointers carry one wrap bit above the index so full/empty need no counter.
module vram_wr_fifo_m #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares the single-port 4 KiB VRAM between GPU fetch reads and
// queued CPU stores.
// Ports:
//   clk_12_5875 : pixel clock, all state on its rising edge
//   rst_B       : asynchronous active-low reset
//   bus         : vram_arbiter_if.slave (CPU store port, GPU read port, VRAM port)
//   stat_clear, stat_forced, stat_dropped : only when VRAM_ARBITER_STATS_EN is defined
// Slot priority: forced CPU slot after MAX_WAIT starved cycles, then GPU, then
// CPU; CPU and GPU swap during vblank. gpu_rd_grant and the VRAM address/write
// controls are combinational from the slot decision so VRAM data returns one
// cycle after grant.
// Stores are not forwarded to later reads; software polls wr_fifo_empty.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic               clk_12_5875,
    input  logic               rst_B,
    vram_arbiter_if.slave      bus
`ifdef VRAM_ARBITER_STATS_EN
    ,
    input  logic               stat_clear,
    output logic [STAT_W-1:0]  stat_forced,
    output logic [STAT_W-1:0]  stat_dropped
`endif
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    wr_entry_t              push_entry;
    wr_entry_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   drop;
    logic                   cpu_slot;
    logic [1:0]             slot;
    logic [7:0]             starve_cnt;
    logic                   overflow;
    logic                   rd_valid;
    logic [VRAM_DATA_W-1:0] rd_hold;

    assign push_entry = '{address: bus.cpu_address, data: bus.cpu_data};
    // Full is judged before any pop this cycle, so a strobe into a full queue is lost
    assign push       = bus.cpu_wr_strobe && !fifo_full;
    assign drop       = bus.cpu_wr_strobe && fifo_full;

    vram_wr_fifo_m #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WR_ENTRY_W)
    ) u_wr_fifo (
        .clk   (clk_12_5875),
        .rst_n (rst_B),
        .push  (push),
        .wdata (push_entry),
        .pop   (cpu_slot),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Slot decision
    always_comb begin
        slot = SLOT_IDLE;
        if (!fifo_empty && (starve_cnt == MAX_WAIT_C)) begin
            slot = SLOT_FORCE;
        end else if (bus.in_vblank && !fifo_empty) begin
            slot = SLOT_CPU;
        end else if (bus.gpu_rd_req) begin
            slot = SLOT_GPU;
        end else if (!fifo_empty) begin
            slot = SLOT_CPU;
        end
    end

    assign cpu_slot = (slot == SLOT_CPU) || (slot == SLOT_FORCE);

    // VRAM port drive
    always_comb begin
        bus.vram_address      = '0;
        bus.vram_data_out     = '0;
        bus.vram_write_enable = 1'b0;
        bus.gpu_rd_grant      = 1'b0;
        if (slot == SLOT_GPU) begin
            bus.gpu_rd_grant = 1'b1;
            bus.vram_address = bus.gpu_rd_address;
        end else if (cpu_slot) begin
            bus.vram_write_enable = 1'b1;
            bus.vram_address      = head.address;
            bus.vram_data_out     = head.data;
        end
    end

    // Starve counter: cycles a non-empty queue went without a CPU slot
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            starve_cnt <= '0;
        end else if (fifo_empty || cpu_slot) begin
            starve_cnt <= '0;
        end else if (starve_cnt != MAX_WAIT_C) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Sticky overflow; a new drop wins over clear
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Read return: valid trails grant by the VRAM latency; data held between reads
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            rd_valid <= 1'b0;
            rd_hold  <= '0;
        end else begin
            rd_valid <= bus.gpu_rd_grant;
            if (rd_valid) rd_hold <= bus.vram_data_in;
        end
    end

    assign bus.gpu_rd_valid  = rd_valid;
    assign bus.gpu_rd_data   = rd_valid ? bus.vram_data_in : rd_hold;
    assign bus.wr_fifo_full  = fifo_full;
    assign bus.wr_fifo_empty = fifo_empty;
    assign bus.wr_overflow   = overflow;

`ifdef VRAM_ARBITER_STATS_EN
    logic [STAT_W-1:0] forced_q;
    logic [STAT_W-1:0] dropped_q;

    // Saturating event counters
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            forced_q  <= '0;
            dropped_q <= '0;
        end else if (stat_clear) begin
            forced_q  <= '0;
            dropped_q <= '0;
        end else begin
            if ((slot == SLOT_FORCE) && (forced_q != '1)) forced_q <= forced_q + STAT_W'(1);
            if (drop && (dropped_q != '1))                dropped_q <= dropped_q + STAT_W'(1);
        end
    end

    assign stat_forced  = forced_q;
    assign stat_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (FIFO_DEPTH=4, MAX_WAIT=8).
// Includes a 4 KiB synchronous VRAM model with one-cycle read latency.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_B = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if bus ();

`ifdef VRAM_ARBITER_STATS_EN
    logic       stat_clear;
    logic [7:0] stat_forced;
    logic [7:0] stat_dropped;
`endif

    vram_arbiter #(
        .FIFO_DEPTH (4),
        .MAX_WAIT   (8)
    ) dut (
        .clk_12_5875 (clk),
        .rst_B       (rst_B),
        .bus         (bus)
`ifdef VRAM_ARBITER_STATS_EN
        ,
        .stat_clear   (stat_clear),
        .stat_forced  (stat_forced),
        .stat_dropped (stat_dropped)
`endif
    );

    int errors = 0;
    int checks = 0;

    // VRAM model and write log
    logic [7:0]  vram [4096];
    logic        cap_we   = 1'b0;
    logic [11:0] cap_addr = '0;
    logic [7:0]  cap_data = '0;
    logic [11:0] log_addr [$];
    logic [7:0]  log_data [$];
    int          log_req_hi = 0;

    always @(negedge clk) begin
        cap_we   = bus.vram_write_enable;
        cap_addr = bus.vram_address;
        cap_data = bus.vram_data_out;
        if (cap_we) begin
            log_addr.push_back(cap_addr);
            log_data.push_back(cap_data);
            if (bus.gpu_rd_req) log_req_hi = log_req_hi + 1;
        end
    end

    always @(posedge clk) begin
        if (cap_we) vram[cap_addr] <= cap_data;
        bus.vram_data_in <= vram[cap_addr];
    end

    task automatic idle_inputs();
        bus.cpu_wr_strobe  = 1'b0;
        bus.cpu_address    = '0;
        bus.cpu_data       = '0;
        bus.clr_overflow   = 1'b0;
        bus.in_vblank      = 1'b0;
        bus.gpu_rd_req     = 1'b0;
        bus.gpu_rd_address = '0;
`ifdef VRAM_ARBITER_STATS_EN
        stat_clear = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_B = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #3 rst_B = 1'b1;
        step();
    endtask

    task automatic strobe(input logic [11:0] a, input logic [7:0] d);
        bus.cpu_wr_strobe = 1'b1;
        bus.cpu_address   = a;
        bus.cpu_data      = d;
        step();
        bus.cpu_wr_strobe = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        idle_inputs();
        bus.vram_data_in = '0;
        #1 rst_B = 1'b0;
        #1;
        checks++; if (bus.wr_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.wr_fifo_empty); end
        checks++; if (bus.wr_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.wr_fifo_full); end
        checks++; if (bus.wr_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.wr_overflow); end
        checks++; if (bus.gpu_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.gpu_rd_valid); end
        checks++; if (bus.gpu_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", bus.gpu_rd_data); end
        checks++; if (bus.vram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.vram_write_enable); end
        checks++; if (bus.vram_address !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", bus.vram_address); end
        checks++; if (bus.vram_data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", bus.vram_data_out); end
        repeat (2) @(posedge clk);
        #3 rst_B = 1'b1;
        step();
        // Queue three stores behind a busy GPU, then reset mid-operation
        bus.gpu_rd_req     = 1'b1;
        bus.gpu_rd_address = 12'h050;
        for (int i = 0; i < 3; i++) strobe(12'(12'h400 + i), 8'(8'h90 + i));
        checks++; if (bus.wr_fifo_empty !== 1'b0) begin errors++; $display("FAIL midop_queued: empty got %b expected 0", bus.wr_fifo_empty); end
        #2 rst_B = 1'b0;
        #1;
        checks++; if (bus.wr_fifo_empty !== 1'b1) begin errors++; $display("FAIL midop_reset_empty: got %b expected 1", bus.wr_fifo_empty); end
        idle_inputs();
        repeat (2) @(posedge clk);
        #3 rst_B = 1'b1;
        step();
        base = log_addr.size();
        repeat (12) step();
        checks++; if (log_addr.size() - base != 0) begin errors++; $display("FAIL midop_no_write: got %0d writes expected 0", log_addr.size() - base); end
        checks++; if (bus.wr_fifo_empty !== 1'b1) begin errors++; $display("FAIL midop_after_empty: got %b expected 1", bus.wr_fifo_empty); end
    endtask

    task automatic test_force();
        int         first;
        logic [11:0] addr9;
        logic [7:0]  data9;
        logic        grant9;
        logic        grant8;
        do_reset();
        bus.gpu_rd_req     = 1'b1;
        bus.gpu_rd_address = 12'h010;
        strobe(12'h123, 8'hA5);
        first  = -1;
        addr9  = '0;
        data9  = '0;
        grant9 = 1'b1;
        grant8 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus.vram_write_enable && first < 0) first = n;
            if (n == 8) grant8 = bus.gpu_rd_grant;
            if (n == 9) begin
                addr9  = bus.vram_address;
                data9  = bus.vram_data_out;
                grant9 = bus.gpu_rd_grant;
            end
            step();
        end
        checks++; if (first != 9) begin errors++; $display("FAIL force_cycle: got %0d expected 9", first); end
        checks++; if (addr9 !== 12'h123) begin errors++; $display("FAIL force_addr: got %h expected 123", addr9); end
        checks++; if (data9 !== 8'hA5) begin errors++; $display("FAIL force_data: got %h expected a5", data9); end
        checks++; if (grant9 !== 1'b0) begin errors++; $display("FAIL force_grant: got %b expected 0", grant9); end
        checks++; if (grant8 !== 1'b1) begin errors++; $display("FAIL force_prev_grant: got %b expected 1", grant8); end
        checks++; if (bus.wr_fifo_empty !== 1'b1) begin errors++; $display("FAIL force_drained: got %b expected 1", bus.wr_fifo_empty); end
`ifdef VRAM_ARBITER_STATS_EN
        checks++; if (stat_forced !== 8'd1) begin errors++; $display("FAIL force_stat: got %0d expected 1", stat_forced); end
`endif
        idle_inputs();
    endtask

    task automatic test_alternate();
        int base;
        int base_hi;
        do_reset();
        base    = log_addr.size();
        base_hi = log_req_hi;
        bus.gpu_rd_req     = 1'b1;
        bus.gpu_rd_address = 12'h0AA;
        for (int i = 0; i < 4; i++) strobe(12'(12'h200 + i), 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            bus.gpu_rd_req = (i % 2 == 1);
            step();
        end
        bus.gpu_rd_req = 1'b0;
        step();
        checks++; if (log_addr.size() - base != 4) begin errors++; $display("FAIL alt_count: got %0d expected 4", log_addr.size() - base); end
        for (int i = 0; i < 4; i++) begin
            if (base + i < log_addr.size()) begin
                checks++;
                if (log_addr[base + i] !== 12'(12'h200 + i) || log_data[base + i] !== 8'(8'h10 + i)) begin
                    errors++;
                    $display("FAIL alt_order[%0d]: got %h/%h expected %h/%h", i, log_addr[base + i], log_data[base + i], 12'(12'h200 + i), 8'(8'h10 + i));
                end
            end
        end
        checks++; if (log_req_hi - base_hi != 0) begin errors++; $display("FAIL alt_gpu_idle: got %0d writes during gpu req expected 0", log_req_hi - base_hi); end
        checks++; if (bus.wr_fifo_empty !== 1'b1) begin errors++; $display("FAIL alt_drained: got %b expected 1", bus.wr_fifo_empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.gpu_rd_req     = 1'b1;
        bus.gpu_rd_address = 12'h030;
        for (int i = 0; i < 5; i++) strobe(12'(12'h500 + i), 8'(8'h20 + i));
        step();
        @(negedge clk);
        checks++; if (bus.wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.wr_overflow); end
        checks++; if (bus.wr_fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", bus.wr_fifo_full); end
`ifdef VRAM_ARBITER_STATS_EN
        checks++; if (stat_dropped !== 8'd1) begin errors++; $display("FAIL ovf_stat: got %0d expected 1", stat_dropped); end
`endif
        bus.clr_overflow = 1'b1;
        step();
        bus.clr_overflow = 1'b0;
        @(negedge clk);
        checks++; if (bus.wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.wr_overflow); end
        step();
        idle_inputs();
    endtask

    task automatic test_read();
        do_reset();
        bus.gpu_rd_req     = 1'b1;
        bus.gpu_rd_address = 12'h7FF;
        @(negedge clk);
        checks++; if (bus.gpu_rd_grant !== 1'b1) begin errors++; $display("FAIL rd_grant: got %b expected 1", bus.gpu_rd_grant); end
        checks++; if (bus.vram_address !== 12'h7FF) begin errors++; $display("FAIL rd_addr: got %h expected 7ff", bus.vram_address); end
        step();
        bus.gpu_rd_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.gpu_rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b expected 1", bus.gpu_rd_valid); end
        checks++; if (bus.gpu_rd_data !== 8'h3C) begin errors++; $display("FAIL rd_data: got %h expected 3c", bus.gpu_rd_data); end
        step();
        @(negedge clk);
        checks++; if (bus.gpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %b expected 0", bus.gpu_rd_valid); end
        checks++; if (bus.gpu_rd_data !== 8'h3C) begin errors++; $display("FAIL rd_hold: got %h expected 3c", bus.gpu_rd_data); end
        step();
    endtask

    task automatic test_vblank();
        logic [13:0] got;
        logic [13:0] exp;
        do_reset();
        bus.gpu_rd_req     = 1'b1;
        bus.gpu_rd_address = 12'h020;
        for (int i = 0; i < 4; i++) strobe(12'(12'h300 + i), 8'(8'h40 + i));
        bus.in_vblank = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            got = {bus.vram_write_enable, bus.gpu_rd_grant, bus.vram_address};
            exp = (n <= 4) ? {1'b1, 1'b0, 12'(12'h300 + n - 1)} : {1'b0, 1'b1, 12'h020};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL vblank_slot[%0d]: got we/grant/addr %h expected %h", n, got, exp);
            end
            step();
        end
`ifdef VRAM_ARBITER_STATS_EN
        checks++; if (stat_forced !== 8'd0) begin errors++; $display("FAIL vblank_stat_forced: got %0d expected 0", stat_forced); end
        checks++; if (stat_dropped !== 8'd0) begin errors++; $display("FAIL vblank_stat_dropped: got %0d expected 0", stat_dropped); end
`endif
        idle_inputs();
    endtask

    task automatic test_full_pop();
        int base;
        do_reset();
        base = log_addr.size();
        bus.gpu_rd_req     = 1'b1;
        bus.gpu_rd_address = 12'h040;
        for (int i = 0; i < 4; i++) strobe(12'(12'h600 + i), 8'(8'h70 + i));
        // Pop and strobe in the same cycle while full: strobe must still drop
        bus.in_vblank = 1'b1;
        strobe(12'h3FF, 8'hEE);
        @(negedge clk);
        checks++; if (bus.wr_overflow !== 1'b1) begin errors++; $display("FAIL fullpop_ovf: got %b expected 1", bus.wr_overflow); end
        repeat (5) step();
        checks++; if (log_addr.size() - base != 4) begin errors++; $display("FAIL fullpop_count: got %0d expected 4", log_addr.size() - base); end
        if (log_addr.size() > 0) begin
            checks++;
            if (log_addr[log_addr.size() - 1] !== 12'h603) begin errors++; $display("FAIL fullpop_last: got %h expected 603", log_addr[log_addr.size() - 1]); end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) vram[i] = 8'(i) ^ 8'h5A;
        vram[12'h7FF] = 8'h3C;
        test_reset();
        test_force();
        test_alternate();
        test_overflow();
        test_read();
        test_vblank();
        test_full_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
